// File: rtl/ocp_slave_mem_if.sv
// rtl/ocp_slave_mem_if.sv - OCP request/response bundle between master and ocp_slave_mem
//
// Purpose: carries one OCP request/data/response channel set.
// Ports:
//   master modport: drives MCmd/MAddr/MTagID/Mdata/MDataValid/MRespAccept,
//                   observes SCmdAccept/SDataAccept/SResp/SData/STagID
//   slave modport : the mirror image of master
interface ocp_slave_mem_if #(
   parameter int AW   = 32,
   parameter int DW   = 32,
   parameter int TAGW = 3
) ();
   logic [2:0]      MCmd;
   logic [AW-1:0]   MAddr;
   logic [TAGW-1:0] MTagID;
   logic [DW-1:0]   Mdata;
   logic            MDataValid;
   logic            MRespAccept;
   logic            SCmdAccept;
   logic            SDataAccept;
   logic [1:0]      SResp;
   logic [DW-1:0]   SData;
   logic [TAGW-1:0] STagID;

   modport master (
      output MCmd, MAddr, MTagID, Mdata, MDataValid, MRespAccept,
      input  SCmdAccept, SDataAccept, SResp, SData, STagID
   );

   modport slave (
      input  MCmd, MAddr, MTagID, Mdata, MDataValid, MRespAccept,
      output SCmdAccept, SDataAccept, SResp, SData, STagID
   );
endinterface

// File: rtl/ocp_slave_mem.sv
// rtl/ocp_slave_mem.sv - OCP slave responder backed by a word memory
//
// Purpose: accepts one OCP request at a time, writes/reads an internal
// MEM_WORDS x DW memory, and returns DVA/ERR responses held until accepted.
// Reads respond exactly RD_LATENCY cycles after the command accept.
// Ports:
//   clk       : clock
//   rst       : asynchronous active-high reset (memory contents retained)
//   ocp_if    : OCP slave side (command, write data, response)
//   err_cnt   : number of ERR responses issued, saturating at 255
//   proto_err : sticky, write data seen with no write pending
module ocp_slave_mem #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int TAGW       = 3,
   parameter int MEM_WORDS  = 4096,
   parameter int RD_LATENCY = 2
) (
   input  logic            clk,
   input  logic            rst,
   ocp_slave_mem_if.slave  ocp_if,
   output logic [7:0]      err_cnt,
   output logic            proto_err
);
   localparam int         IW       = $clog2(MEM_WORDS);
   localparam logic [3:0] LAT_LOAD = 4'(RD_LATENCY - 1);

   localparam logic [2:0] CMD_WR = 3'd1;
   localparam logic [2:0] CMD_RD = 3'd2;
   localparam logic [1:0] RESP_NULL = 2'd0;
   localparam logic [1:0] RESP_DVA  = 2'd1;
   localparam logic [1:0] RESP_ERR  = 2'd3;

   typedef enum logic [1:0] {ST_IDLE, ST_WDATA, ST_RD_WAIT, ST_RESP} state_t;

   state_t          r_state;
   logic [3:0]      r_cnt;
   logic [IW-1:0]   r_idx;
   logic [TAGW-1:0] r_tag;
   logic            r_scmd_accept;
   logic            r_sdata_accept;
   logic [1:0]      r_sresp;
   logic [DW-1:0]   r_sdata;
   logic [TAGW-1:0] r_stag;
   logic [7:0]      r_err_cnt;
   logic            r_proto_err;
   logic [DW-1:0]   r_mem [MEM_WORDS];

   logic [IW-1:0]   w_idx;
   logic            w_oor;
   logic            w_accept;
   logic            w_err;
   logic            w_we;
   logic [IW-1:0]   w_widx;
   logic            w_data_ok;
   logic            w_unused;

   assign w_idx    = ocp_if.MAddr[IW+1:2];
   assign w_oor    = |ocp_if.MAddr[AW-1:IW+2];
   assign w_accept = (r_state == ST_IDLE) && r_scmd_accept && (ocp_if.MCmd != 3'd0);
   // Anything other than RD/WR is reserved and answered with ERR.
   assign w_err    = w_accept && ((ocp_if.MCmd > CMD_RD) || w_oor);
   // Data is expected only alongside an accepted WR or while waiting for it.
   assign w_data_ok = (w_accept && ocp_if.MCmd == CMD_WR) || (r_state == ST_WDATA);
   assign w_unused  = ^ocp_if.MAddr[1:0];

   always_comb begin
      w_we   = 1'b0;
      w_widx = w_idx;
      if (w_accept && !w_err && ocp_if.MCmd == CMD_WR && ocp_if.MDataValid) begin
         w_we = 1'b1;
      end else if (r_state == ST_WDATA && ocp_if.MDataValid) begin
         w_we   = 1'b1;
         w_widx = r_idx;
      end
   end

   // No reset: committed contents survive a reset.
   always_ff @(posedge clk) begin
      if (w_we) begin
         r_mem[w_widx] <= ocp_if.Mdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= ST_IDLE;
         r_cnt          <= '0;
         r_idx          <= '0;
         r_tag          <= '0;
         r_scmd_accept  <= 1'b0;
         r_sdata_accept <= 1'b0;
         r_sresp        <= RESP_NULL;
         r_sdata        <= '0;
         r_stag         <= '0;
         r_err_cnt      <= '0;
         r_proto_err    <= 1'b0;
      end else begin
         if (ocp_if.MDataValid && !w_data_ok) begin
            r_proto_err <= 1'b1;
         end
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_scmd_accept <= 1'b0;
                  r_tag         <= ocp_if.MTagID;
                  r_idx         <= w_idx;
                  if (w_err) begin
                     r_sresp <= RESP_ERR;
                     r_sdata <= '0;
                     r_stag  <= ocp_if.MTagID;
                     r_state <= ST_RESP;
                     if (r_err_cnt != 8'hFF) begin
                        r_err_cnt <= r_err_cnt + 8'd1;
                     end
                  end else if (ocp_if.MCmd == CMD_RD) begin
                     // Latency 1 has no wait cycle: respond straight from the accept.
                     if (RD_LATENCY == 1) begin
                        r_sresp <= RESP_DVA;
                        r_sdata <= r_mem[w_idx];
                        r_stag  <= ocp_if.MTagID;
                        r_state <= ST_RESP;
                     end else begin
                        r_cnt   <= LAT_LOAD;
                        r_state <= ST_RD_WAIT;
                     end
                  end else if (ocp_if.MDataValid) begin
                     r_sresp <= RESP_DVA;
                     r_sdata <= '0;
                     r_stag  <= ocp_if.MTagID;
                     r_state <= ST_RESP;
                  end else begin
                     r_sdata_accept <= 1'b1;
                     r_state        <= ST_WDATA;
                  end
               end else begin
                  r_scmd_accept <= 1'b1;
               end
            end
            ST_WDATA: begin
               if (ocp_if.MDataValid) begin
                  r_sdata_accept <= 1'b0;
                  r_sresp        <= RESP_DVA;
                  r_sdata        <= '0;
                  r_stag         <= r_tag;
                  r_state        <= ST_RESP;
               end
            end
            ST_RD_WAIT: begin
               // Responding at count 1 makes SResp visible RD_LATENCY cycles after accept.
               if (r_cnt == 4'd1) begin
                  r_sresp <= RESP_DVA;
                  r_sdata <= r_mem[r_idx];
                  r_stag  <= r_tag;
                  r_state <= ST_RESP;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            ST_RESP: begin
               if (ocp_if.MRespAccept) begin
                  r_sresp       <= RESP_NULL;
                  r_sdata       <= '0;
                  r_stag        <= '0;
                  r_scmd_accept <= 1'b1;
                  r_state       <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign ocp_if.SCmdAccept  = r_scmd_accept;
   assign ocp_if.SDataAccept = r_sdata_accept;
   assign ocp_if.SResp       = r_sresp;
   assign ocp_if.SData       = r_sdata;
   assign ocp_if.STagID      = r_stag;
   assign err_cnt            = r_err_cnt;
   assign proto_err          = r_proto_err;
endmodule

// File: tb/tb_ocp_slave_mem.sv
// tb/tb_ocp_slave_mem.sv - directed self-checking bench for ocp_slave_mem
module tb_ocp_slave_mem;
   localparam int RD_LAT = 2;
   localparam logic [2:0] WR = 3'd1;
   localparam logic [2:0] RD = 3'd2;

   typedef struct {
      logic [2:0]  cmd;
      logic [31:0] addr;
      logic [2:0]  tag;
      logic [31:0] wdata;
      logic [1:0]  resp;
      logic [31:0] rdata;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] err_cnt;
   logic       proto_err;
   int         checks = 0;
   int         failures = 0;
   vec_t       vecs [13];

   ocp_slave_mem_if ocp_if ();

   ocp_slave_mem #(.RD_LATENCY(RD_LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .ocp_if    (ocp_if),
      .err_cnt   (err_cnt),
      .proto_err (proto_err)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   task automatic wait_ready(input string nm);
      int n = 0;
      while (ocp_if.SCmdAccept !== 1'b1 && n < 20) begin
         tick;
         n++;
      end
      check({nm, "_ready"}, 32'(ocp_if.SCmdAccept), 32'd1);
   endtask

   task automatic run_txn(input logic [2:0] cmd, input logic [31:0] addr, input logic [2:0] tag,
                          input logic [31:0] wdata, input logic [1:0] eresp,
                          input logic [31:0] edata, input string nm);
      int lat;
      int elat;
      wait_ready(nm);
      ocp_if.MCmd       = cmd;
      ocp_if.MAddr      = addr;
      ocp_if.MTagID     = tag;
      ocp_if.Mdata      = wdata;
      ocp_if.MDataValid = (cmd == WR);
      tick;
      ocp_if.MCmd       = 3'd0;
      ocp_if.MDataValid = 1'b0;
      lat = 1;
      while (ocp_if.SResp === 2'd0 && lat < 20) begin
         tick;
         lat++;
      end
      elat = (cmd == RD && eresp == 2'd1) ? RD_LAT : 1;
      check({nm, "_lat"},  32'(lat), 32'(elat));
      check({nm, "_resp"}, 32'(ocp_if.SResp), 32'(eresp));
      check({nm, "_data"}, ocp_if.SData, edata);
      check({nm, "_tag"},  32'(ocp_if.STagID), 32'(tag));
      check({nm, "_busy"}, 32'(ocp_if.SCmdAccept), 32'd0);
      ocp_if.MRespAccept = 1'b1;
      tick;
      ocp_if.MRespAccept = 1'b0;
      check({nm, "_rclr"}, 32'(ocp_if.SResp), 32'd0);
      check({nm, "_dclr"}, ocp_if.SData, 32'd0);
      check({nm, "_rdy"},  32'(ocp_if.SCmdAccept), 32'd1);
   endtask

   task automatic check_reset_outputs(input string nm);
      check({nm, "_scmd"},  32'(ocp_if.SCmdAccept), 32'd0);
      check({nm, "_sdacc"}, 32'(ocp_if.SDataAccept), 32'd0);
      check({nm, "_sresp"}, 32'(ocp_if.SResp), 32'd0);
      check({nm, "_sdata"}, ocp_if.SData, 32'd0);
      check({nm, "_stag"},  32'(ocp_if.STagID), 32'd0);
      check({nm, "_errc"},  32'(err_cnt), 32'd0);
      check({nm, "_perr"},  32'(proto_err), 32'd0);
   endtask

   initial begin
      vecs[0]  = '{WR,    32'h0000_0040, 3'd5, 32'hDEAD_BEEF, 2'd1, 32'h0};
      vecs[1]  = '{RD,    32'h0000_0040, 3'd3, 32'h0,         2'd1, 32'hDEAD_BEEF};
      vecs[2]  = '{WR,    32'h0000_0044, 3'd1, 32'hA5A5_0001, 2'd1, 32'h0};
      vecs[3]  = '{WR,    32'h0000_0047, 3'd2, 32'h0BAD_F00D, 2'd1, 32'h0};
      vecs[4]  = '{RD,    32'h0000_0044, 3'd6, 32'h0,         2'd1, 32'h0BAD_F00D};
      vecs[5]  = '{WR,    32'h0000_3FFC, 3'd7, 32'h1111_2222, 2'd1, 32'h0};
      vecs[6]  = '{RD,    32'h0000_3FFF, 3'd0, 32'h0,         2'd1, 32'h1111_2222};
      vecs[7]  = '{WR,    32'h0000_0000, 3'd1, 32'h0000_0055, 2'd1, 32'h0};
      vecs[8]  = '{RD,    32'h0000_4000, 3'd4, 32'h0,         2'd3, 32'h0};
      vecs[9]  = '{3'd5,  32'h0000_0040, 3'd2, 32'h0,         2'd3, 32'h0};
      vecs[10] = '{WR,    32'h0000_4000, 3'd3, 32'h0000_0099, 2'd3, 32'h0};
      vecs[11] = '{RD,    32'h0000_0000, 3'd5, 32'h0,         2'd1, 32'h0000_0055};
      vecs[12] = '{RD,    32'h0000_0040, 3'd6, 32'h0,         2'd1, 32'hDEAD_BEEF};

      ocp_if.MCmd = 3'd0;
      ocp_if.MAddr = '0;
      ocp_if.MTagID = '0;
      ocp_if.Mdata = '0;
      ocp_if.MDataValid = 1'b0;
      ocp_if.MRespAccept = 1'b0;

      tick;
      check_reset_outputs("rst0");
      rst = 1'b0;
      tick;

      for (int i = 0; i < 13; i++) begin
         run_txn(vecs[i].cmd, vecs[i].addr, vecs[i].tag, vecs[i].wdata,
                 vecs[i].resp, vecs[i].rdata, $sformatf("v%0d", i));
      end
      check("err_cnt3", 32'(err_cnt), 32'd3);
      check("perr_clean", 32'(proto_err), 32'd0);

      // Separate data phase, data three cycles after the command.
      wait_ready("wd");
      ocp_if.MCmd = WR; ocp_if.MAddr = 32'h10; ocp_if.MTagID = 3'd2;
      tick;
      ocp_if.MCmd = 3'd0;
      for (int i = 0; i < 3; i++) begin
         check("wd_sdacc", 32'(ocp_if.SDataAccept), 32'd1);
         check("wd_scmd",  32'(ocp_if.SCmdAccept), 32'd0);
         check("wd_sresp", 32'(ocp_if.SResp), 32'd0);
         tick;
      end
      ocp_if.Mdata = 32'h1234; ocp_if.MDataValid = 1'b1;
      tick;
      ocp_if.MDataValid = 1'b0;
      check("wd_resp",  32'(ocp_if.SResp), 32'd1);
      check("wd_tag",   32'(ocp_if.STagID), 32'd2);
      check("wd_data",  ocp_if.SData, 32'd0);
      check("wd_sdoff", 32'(ocp_if.SDataAccept), 32'd0);
      ocp_if.MRespAccept = 1'b1;
      tick;
      ocp_if.MRespAccept = 1'b0;
      run_txn(RD, 32'h10, 3'd4, 32'h0, 2'd1, 32'h1234, "wd_rd");

      // Response held while the master stalls for four cycles.
      wait_ready("hold");
      ocp_if.MCmd = RD; ocp_if.MAddr = 32'h40; ocp_if.MTagID = 3'd6;
      tick;
      ocp_if.MCmd = 3'd0;
      tick;
      for (int i = 0; i < 5; i++) begin
         check("hold_resp", 32'(ocp_if.SResp), 32'd1);
         check("hold_data", ocp_if.SData, 32'hDEAD_BEEF);
         check("hold_tag",  32'(ocp_if.STagID), 32'd6);
         check("hold_scmd", 32'(ocp_if.SCmdAccept), 32'd0);
         if (i == 4) ocp_if.MRespAccept = 1'b1;
         tick;
      end
      ocp_if.MRespAccept = 1'b0;
      check("hold_rclr", 32'(ocp_if.SResp), 32'd0);
      check("hold_rdy",  32'(ocp_if.SCmdAccept), 32'd1);

      // Stray write data in IDLE: flagged, not written.
      ocp_if.MAddr = 32'h40; ocp_if.Mdata = 32'hFFFF_0000; ocp_if.MDataValid = 1'b1;
      tick;
      ocp_if.MDataValid = 1'b0;
      check("perr_set", 32'(proto_err), 32'd1);
      tick;
      check("perr_sticky", 32'(proto_err), 32'd1);
      run_txn(RD, 32'h40, 3'd1, 32'h0, 2'd1, 32'hDEAD_BEEF, "perr_rd");

      // Reset while a read is waiting for its latency.
      wait_ready("rwr");
      ocp_if.MCmd = RD; ocp_if.MAddr = 32'h40; ocp_if.MTagID = 3'd3;
      tick;
      ocp_if.MCmd = 3'd0;
      #2 rst = 1'b1;
      #1 check_reset_outputs("rst_rw");
      tick;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("rst_rw_noresp", 32'(ocp_if.SResp), 32'd0);
         tick;
      end
      run_txn(RD, 32'h40, 3'd2, 32'h0, 2'd1, 32'hDEAD_BEEF, "rst_rw_rd");

      // Reset while a write waits for data: nothing reaches memory.
      wait_ready("rwd");
      ocp_if.MCmd = WR; ocp_if.MAddr = 32'h0; ocp_if.MTagID = 3'd1;
      tick;
      ocp_if.MCmd = 3'd0;
      check("rwd_sdacc", 32'(ocp_if.SDataAccept), 32'd1);
      ocp_if.Mdata = 32'h7777_7777;
      #2 rst = 1'b1;
      #1 check_reset_outputs("rst_wd");
      tick;
      rst = 1'b0;
      run_txn(RD, 32'h0, 3'd7, 32'h0, 2'd1, 32'h0000_0055, "rst_wd_rd");

      // ERR counter saturation.
      for (int k = 0; k < 300; k++) begin
         int n = 0;
         while (ocp_if.SCmdAccept !== 1'b1 && n < 10) begin
            tick;
            n++;
         end
         ocp_if.MCmd = 3'd6;
         tick;
         ocp_if.MCmd = 3'd0;
         ocp_if.MRespAccept = 1'b1;
         tick;
         ocp_if.MRespAccept = 1'b0;
         if (k == 9) check("err_cnt10", 32'(err_cnt), 32'd10);
      end
      check("err_cnt_sat", 32'(err_cnt), 32'd255);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
